// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC sequencer slice.
// Default widths, the controller state encoding, and signed accumulator limits.
package mac_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 20;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mac_state_e;

   // Largest and smallest value representable in a signed acc_w-bit accumulator.
   function automatic logic signed [63:0] acc_lim_hi(input int acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_lim_lo(input int acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream and result handshake between feeder, MAC sequencer and collector.
// master drives operands and result backpressure; slave is the sequencer.
interface mac_seq_ctrl_if #(
   parameter int DATA_W = mac_pkg::DEF_DATA_W,
   parameter int ACC_W  = mac_pkg::DEF_ACC_W
);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_a;
   logic signed [DATA_W-1:0] in_b;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  acc_out;
   logic                     overflow;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, acc_out, overflow
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, acc_out, overflow
   );

endinterface

// File: rtl/mac_seq_ctrl_pe.sv
// Combinational signed multiply-accumulate step with overflow detect.
// Clamps to the accumulator limits when MAC_SEQ_SATURATE_EN is defined, wraps otherwise.
module mac_pe
   import mac_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  acc_next,
   output logic                     ovf
);

   localparam int PW = 2 * DATA_W;

   logic signed [PW-1:0] a_x;
   logic signed [PW-1:0] b_x;
   logic signed [PW-1:0] prod;
   logic signed [ACC_W:0] sum;

   assign a_x  = {{DATA_W{a[DATA_W-1]}}, a};
   assign b_x  = {{DATA_W{b[DATA_W-1]}}, b};
   assign prod = a_x * b_x;

   // One guard bit holds the true sum, so overflow is a disagreement of the top two bits.
   assign sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PW){prod[PW-1]}}, prod};
   assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef MAC_SEQ_SATURATE_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_lim_hi(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_lim_lo(ACC_W));

   always_comb begin
      acc_next = sum[ACC_W-1:0];
      if (ovf) begin
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end
`else
   assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC datapath sequencer: takes a length-N command, accumulates N operand-pair products,
// then holds the result until collected. Optional clamping via MAC_SEQ_SATURATE_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; len latched and acc cleared on accept
// ST_RUN  | in_ready high; one product accumulated per beat
// ST_DONE | out_valid high; acc_out/overflow held until out_ready
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   mac_seq_ctrl_if.slave     bus
);

   mac_state_e              state;
   logic [LEN_W-1:0]        beats_left;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic                    step_ovf;
   logic                    overflow_q;

   mac_pe #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_pe (
      .a        (bus.in_a),
      .b        (bus.in_b),
      .acc      (acc),
      .acc_next (acc_next),
      .ovf      (step_ovf)
   );

   assign bus.acc_out  = acc;
   assign bus.overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         beats_left    <= '0;
         acc           <= '0;
         overflow_q    <= 1'b0;
         busy          <= 1'b0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc        <= '0;
                  overflow_q <= 1'b0;
                  beats_left <= len;
                  busy       <= 1'b1;
                  if (len == '0) begin
                     state         <= ST_DONE;
                     bus.out_valid <= 1'b1;
                  end else begin
                     state        <= ST_RUN;
                     bus.in_ready <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.in_valid && bus.in_ready) begin
                  acc        <= acc_next;
                  beats_left <= beats_left - LEN_W'(1);
                  if (step_ovf) begin
                     overflow_q <= 1'b1;
                  end
                  // Down-counter terminal count: this beat is the last of the command.
                  if (beats_left == LEN_W'(1)) begin
                     state         <= ST_DONE;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state         <= ST_IDLE;
                  bus.out_valid <= 1'b0;
                  busy          <= 1'b0;
               end
            end
            default: begin
               state         <= ST_IDLE;
               busy          <= 1'b0;
               bus.in_ready  <= 1'b0;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: two instances (ACC_W 20 and 16) share stimulus
// and are compared every cycle against a transaction-level arithmetic model.
module tb_mac_seq_ctrl;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        len = '0;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_a = '0;
   logic signed [7:0] in_b = '0;
   logic              out_ready = 1'b0;
   logic              busy20;
   logic              busy16;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mac_seq_ctrl_if #(.DATA_W(8), .ACC_W(20)) if20 ();
   mac_seq_ctrl_if #(.DATA_W(8), .ACC_W(16)) if16 ();

   assign if20.in_valid  = in_valid;
   assign if20.in_a      = in_a;
   assign if20.in_b      = in_b;
   assign if20.out_ready = out_ready;
   assign if16.in_valid  = in_valid;
   assign if16.in_a      = in_a;
   assign if16.in_b      = in_b;
   assign if16.out_ready = out_ready;

   mac_seq_ctrl #(.DATA_W(8), .ACC_W(20), .LEN_W(8)) d20 (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy20), .bus(if20));
   mac_seq_ctrl #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) d16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16), .bus(if16));

   // ---------------- reference model ----------------
   bit     m_busy, m_in_ready, m_out_valid, m_clean;
   int     m_len, m_cnt;
   longint m_acc20, m_acc16;
   bit     m_ovf20, m_ovf16;

   function automatic void mac_step(input int w, input longint p, inout longint acc, inout bit ovf);
      longint lo, hi, t, m, r;
      lo = -(longint'(1) <<< (w - 1));
      hi = (longint'(1) <<< (w - 1)) - 1;
      t  = acc + p;
      if (t < lo || t > hi) ovf = 1'b1;
`ifdef MAC_SEQ_SATURATE_EN
      acc = (t < lo) ? lo : ((t > hi) ? hi : t);
`else
      m = longint'(1) <<< w;
      r = (t - lo) % m;
      if (r < 0) r = r + m;
      acc = r + lo;
`endif
   endfunction

   always @(posedge clk) begin
      longint p;
      if (rst) begin
         m_busy = 0; m_in_ready = 0; m_out_valid = 0; m_clean = 1;
         m_len = 0; m_cnt = 0; m_acc20 = 0; m_acc16 = 0; m_ovf20 = 0; m_ovf16 = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_clean = 0; m_len = int'(len); m_cnt = 0;
            m_acc20 = 0; m_acc16 = 0; m_ovf20 = 0; m_ovf16 = 0;
            if (m_len == 0) m_out_valid = 1;
            else m_in_ready = 1;
         end
      end else if (m_in_ready) begin
         if (in_valid) begin
            p = longint'(in_a) * longint'(in_b);
            mac_step(20, p, m_acc20, m_ovf20);
            mac_step(16, p, m_acc16, m_ovf16);
            m_cnt++;
            if (m_cnt == m_len) begin
               m_in_ready = 0;
               m_out_valid = 1;
            end
         end
      end else if (m_out_valid && out_ready) begin
         m_busy = 0;
         m_out_valid = 0;
      end
   end

   task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy20", 64'(busy20), 64'(m_busy));
         check("busy16", 64'(busy16), 64'(m_busy));
         check("in_ready20", 64'(if20.in_ready), 64'(m_in_ready));
         check("in_ready16", 64'(if16.in_ready), 64'(m_in_ready));
         check("out_valid20", 64'(if20.out_valid), 64'(m_out_valid));
         check("out_valid16", 64'(if16.out_valid), 64'(m_out_valid));
         if (m_out_valid || m_clean) begin
            check("acc_out20", if20.acc_out, m_acc20);
            check("acc_out16", if16.acc_out, m_acc16);
            check("overflow20", 64'(if20.overflow), 64'(m_ovf20));
            check("overflow16", 64'(if16.overflow), 64'(m_ovf16));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; in_valid = 0; out_ready = 0; start = 0;
      cycle(); cycle();
      rst = 0;
   endtask

   task automatic start_cmd(input int l);
      start = 1; len = 8'(l);
      cycle();
      start = 0;
   endtask

   task automatic feed(input int a, input int b, input int gap, input bit noise);
      bit rdy;
      int n;
      repeat (gap) begin
         in_a = 8'($urandom); in_b = 8'($urandom);
         cycle();
      end
      in_valid = 1; in_a = 8'(a); in_b = 8'(b); n = 0;
      do begin
         rdy = if16.in_ready;
         if (noise && $urandom_range(0, 2) == 0) begin
            start = 1; len = 8'($urandom);
         end
         cycle();
         start = 0;
         n++;
      end while (!rdy && n < 50);
      in_valid = 0;
      if (!rdy) begin
         n_cmp++; n_bad++;
         $display("FAIL feed_timeout: got in_ready 0 expected 1 within 50 cycles");
      end
   endtask

   task automatic collect(input int delay, input bit noise);
      int n = 0;
      while (!if16.out_valid && n < 100) begin
         cycle(); n++;
      end
      if (!if16.out_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL result_timeout: got out_valid 0 expected 1 within 100 cycles");
      end else begin
         repeat (delay) cycle();
         out_ready = 1;
         if (noise) begin
            start = 1; len = 8'($urandom_range(1, 9));
         end
         cycle();
         out_ready = 0; start = 0;
      end
   endtask

   task automatic expect_res(input string nm, input longint e20, input longint o20,
                             input longint e16, input longint o16);
      check({nm, "_acc20"}, if20.acc_out, e20);
      check({nm, "_ovf20"}, 64'(if20.overflow), o20);
      check({nm, "_acc16"}, if16.acc_out, e16);
      check({nm, "_ovf16"}, 64'(if16.overflow), o16);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      int l, k;
      do_reset();
      chk_en = 1;
      check("rst_busy", 64'(busy20), 0);
      check("rst_out_valid", 64'(if16.out_valid), 0);
      check("rst_acc_out", if20.acc_out, 0);

      // basic dot product
      start_cmd(3);
      feed(1, 2, 0, 0); feed(-1, -1, 0, 0); feed(127, 127, 0, 0);
      check("basic_latency", 64'(if20.out_valid), 1);
      expect_res("basic", 16132, 0, 16132, 0);
      collect(0, 0);

      // stalls and result backpressure
      start_cmd(2);
      feed(-128, -128, 3, 0); feed(-128, 127, 3, 0);
      repeat (5) cycle();
      expect_res("stall", 128, 0, 128, 0);
      collect(0, 0);
      check("stall_idle", 64'(busy16), 0);

      // zero-length command
      start_cmd(0);
      check("len0_out_valid", 64'(if16.out_valid), 1);
      expect_res("len0", 0, 0, 0, 0);
      collect(2, 0);

      // overflow on the narrow accumulator
      start_cmd(3);
      repeat (3) feed(-128, -128, 0, 0);
`ifdef MAC_SEQ_SATURATE_EN
      expect_res("ovf3", 49152, 0, 32767, 1);
`else
      expect_res("ovf3", 49152, 0, -16384, 1);
`endif
      collect(1, 0);

      // start pulses while busy are ignored
      start_cmd(2);
      start = 1; len = 8'd7; cycle(); start = 0;
      feed(10, 10, 0, 1); feed(-3, 4, 1, 1);
      expect_res("busy_start", 88, 0, 88, 0);
      collect(1, 1);
      check("busy_start_idle", 64'(busy20), 0);

      // reset in the middle of a command
      start_cmd(4);
      feed(9, 9, 0, 0); feed(7, 7, 0, 0);
      rst = 1; cycle();
      check("midrst_busy", 64'(busy16), 0);
      check("midrst_out_valid", 64'(if20.out_valid), 0);
      check("midrst_acc_out", if16.acc_out, 0);
      rst = 0;
      start_cmd(1);
      feed(3, 5, 0, 0);
      expect_res("midrst", 15, 0, 15, 0);
      collect(0, 0);

      // long run overflowing both widths
      start_cmd(40);
      repeat (40) feed(-128, -128, 0, 0);
`ifdef MAC_SEQ_SATURATE_EN
      expect_res("long", 524287, 1, 32767, 1);
`else
      expect_res("long", -393216, 1, 0, 1);
`endif
      collect(0, 0);

      // randomized commands
      for (int c = 0; c < 40; c++) begin
         k = $urandom_range(0, 9);
         l = (k == 0) ? 0 : ((k == 1) ? $urandom_range(20, 45) : $urandom_range(1, 8));
         repeat ($urandom_range(0, 2)) cycle();
         start_cmd(l);
         for (int i = 0; i < l; i++) begin
            if (k == 1) feed(-128 + 255 * $urandom_range(0, 1), -128, $urandom_range(0, 1), 1);
            else feed($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                      $urandom_range(0, 2), 1);
         end
         collect($urandom_range(0, 3), $urandom_range(0, 1));
      end

      repeat (3) cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
